// File: rtl/fp_pkg.sv
// Shared constants and operand-source encoding for the FP register file with forwarding.
package fp_pkg;

  localparam int FP_NREG  = 32;
  localparam int FP_IDX_W = 5;
  localparam int FP_W     = 32;

  typedef enum logic [1:0] {
    SRC_RF = 2'd0,
    SRC_WB = 2'd1,
    SRC_E3 = 2'd2
  } src_e;

endpackage

// File: rtl/fp_fwd_sel.sv
// Per-operand source select and hazard detect.
// With FP_E3_FWD_EN defined, E3 results are forwarded; otherwise a match in E3 stalls.
module fp_fwd_sel
  import fp_pkg::*;
(
  input  logic [FP_IDX_W-1:0] idx_i,
  input  logic                use_i,
  input  logic [FP_IDX_W-1:0] e1n_i,
  input  logic                e1w_i,
  input  logic [FP_IDX_W-1:0] e2n_i,
  input  logic                e2w_i,
  input  logic [FP_IDX_W-1:0] e3n_i,
  input  logic                e3w_i,
  input  logic [FP_IDX_W-1:0] wn_i,
  input  logic                ww_i,
  output src_e                src_o,
  output logic                hazard_o
);

  logic hit_e1, hit_e2, hit_e3, hit_wb;

  assign hit_e1 = e1w_i && (e1n_i == idx_i);
  assign hit_e2 = e2w_i && (e2n_i == idx_i);
  assign hit_e3 = e3w_i && (e3n_i == idx_i);
  assign hit_wb = ww_i  && (wn_i  == idx_i);

`ifdef FP_E3_FWD_EN
  assign hazard_o = use_i && (hit_e1 || hit_e2);

  always_comb begin
    src_o = SRC_RF;
    if (hit_e3)      src_o = SRC_E3;
    else if (hit_wb) src_o = SRC_WB;
  end
`else
  // Without the E3 bypass, the E3 result is only visible once it reaches write-back.
  assign hazard_o = use_i && (hit_e1 || hit_e2 || hit_e3);

  always_comb begin
    src_o = SRC_RF;
    if (hit_wb) src_o = SRC_WB;
  end
`endif

endmodule

// File: rtl/fp_regfile_fwd.sv
// 32x32 FP register file with E3/write-back forwarding, hazard stall and stall counter.
// Optional macro FP_E3_FWD_EN enables E3 forwarding (otherwise E3 matches stall).
module fp_regfile_fwd
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FP_IDX_W-1:0] fs,
  input  logic [FP_IDX_W-1:0] ft,
  input  logic                use_fs,
  input  logic                use_ft,
  input  logic [FP_IDX_W-1:0] e1n,
  input  logic [FP_IDX_W-1:0] e2n,
  input  logic [FP_IDX_W-1:0] e3n,
  input  logic                e1w,
  input  logic                e2w,
  input  logic                e3w,
  input  logic [FP_W-1:0]     ed,
  input  logic [FP_IDX_W-1:0] wn,
  input  logic                ww,
  input  logic [FP_W-1:0]     wd,
  output logic [FP_W-1:0]     qa,
  output logic [FP_W-1:0]     qb,
  output logic                stall,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [FP_W-1:0]  regs_q [FP_NREG];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  src_e             src_a, src_b;
  logic             haz_a, haz_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fp_fwd_sel u_sel_fs (
    .idx_i(fs), .use_i(use_fs),
    .e1n_i(e1n), .e1w_i(e1w), .e2n_i(e2n), .e2w_i(e2w), .e3n_i(e3n), .e3w_i(e3w),
    .wn_i(wn), .ww_i(ww), .src_o(src_a), .hazard_o(haz_a)
  );

  fp_fwd_sel u_sel_ft (
    .idx_i(ft), .use_i(use_ft),
    .e1n_i(e1n), .e1w_i(e1w), .e2n_i(e2n), .e2w_i(e2w), .e3n_i(e3n), .e3w_i(e3w),
    .wn_i(wn), .ww_i(ww), .src_o(src_b), .hazard_o(haz_b)
  );

  assign stall = haz_a || haz_b;

  always_comb begin
    case (src_a)
      SRC_E3:  qa = ed;
      SRC_WB:  qa = wd;
      default: qa = regs_q[fs];
    endcase
    case (src_b)
      SRC_E3:  qb = ed;
      SRC_WB:  qb = wd;
      default: qb = regs_q[ft];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FP_NREG; i++) regs_q[i] <= '0;
    end else if (ww) begin
      regs_q[wn] <= wd;
    end
  end

  // Clear wins over increment; increment saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr)    stall_cnt_d = '0;
    else if (stall) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fp_regfile_fwd.sv
// Directed self-checking bench for fp_regfile_fwd (default and CNT_W=2 instances).
module tb_fp_regfile_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  fs, ft, e1n, e2n, e3n, wn;
  logic        use_fs, use_ft, e1w, e2w, e3w, ww, cnt_clr;
  logic [31:0] ed, wd, qa, qb, qa2, qb2;
  logic        stall, stall2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_regfile_fwd #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fs(fs), .ft(ft), .use_fs(use_fs), .use_ft(use_ft),
    .e1n(e1n), .e2n(e2n), .e3n(e3n), .e1w(e1w), .e2w(e2w), .e3w(e3w), .ed(ed),
    .wn(wn), .ww(ww), .wd(wd), .qa(qa), .qb(qb), .stall(stall),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  fp_regfile_fwd #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .fs(fs), .ft(ft), .use_fs(use_fs), .use_ft(use_ft),
    .e1n(e1n), .e2n(e2n), .e3n(e3n), .e1w(e1w), .e2w(e2w), .e3w(e3w), .ed(ed),
    .wn(wn), .ww(ww), .wd(wd), .qa(qa2), .qb(qb2), .stall(stall2),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt2)
  );

  task automatic idle_inputs();
    fs = 5'd0; ft = 5'd0; use_fs = 1'b0; use_ft = 1'b0;
    e1n = 5'd0; e2n = 5'd0; e3n = 5'd0; e1w = 1'b0; e2w = 1'b0; e3w = 1'b0;
    ed = 32'h0; wn = 5'd0; ww = 1'b0; wd = 32'h0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fs = 5'd7; ft = 5'd31; use_fs = 1'b1; use_ft = 1'b1;
    #1;
    checks++; if (qa !== 32'h0) begin errors++; $display("FAIL reset_qa got %h want %h", qa, 32'h0); end
    checks++; if (qb !== 32'h0) begin errors++; $display("FAIL reset_qb got %h want %h", qb, 32'h0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    checks++; if (stall_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d want 0", stall_cnt2); end
  endtask

  task automatic test_write_through();
    @(negedge clk);
    idle_inputs();
    ww = 1'b1; wn = 5'd5; wd = 32'h3F80_0000; fs = 5'd5; use_fs = 1'b1; ft = 5'd6;
    #1;
    checks++; if (qa !== 32'h3F80_0000) begin errors++; $display("FAIL wt_same_cycle got %h want %h", qa, 32'h3F80_0000); end
    checks++; if (qb !== 32'h0) begin errors++; $display("FAIL wt_other_reg got %h want %h", qb, 32'h0); end
    @(posedge clk); #1;
    ww = 1'b0; wd = 32'hFFFF_FFFF; ft = 5'd5;
    #1;
    checks++; if (qa !== 32'h3F80_0000) begin errors++; $display("FAIL wt_array_qa got %h want %h", qa, 32'h3F80_0000); end
    checks++; if (qb !== 32'h3F80_0000) begin errors++; $display("FAIL wt_array_qb got %h want %h", qb, 32'h3F80_0000); end
    // f0 is a real register
    @(negedge clk);
    ww = 1'b1; wn = 5'd0; wd = 32'hC0A0_0000;
    @(posedge clk); #1;
    ww = 1'b0; fs = 5'd0;
    #1;
    checks++; if (qa !== 32'hC0A0_0000) begin errors++; $display("FAIL f0_not_zero got %h want %h", qa, 32'hC0A0_0000); end
  endtask

  task automatic test_e3_forward();
    @(negedge clk);
    idle_inputs();
    e3w = 1'b1; e3n = 5'd2; ed = 32'h4000_0000;
    ww = 1'b1; wn = 5'd2; wd = 32'h1111_1111; ft = 5'd2; use_ft = 1'b1; fs = 5'd2;
    #1;
`ifdef FP_E3_FWD_EN
    checks++; if (qb !== 32'h4000_0000) begin errors++; $display("FAIL e3_fwd_qb got %h want %h", qb, 32'h4000_0000); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL e3_fwd_stall got %b want 0", stall); end
    checks++; if (qa !== 32'h4000_0000) begin errors++; $display("FAIL e3_fwd_qa_unused got %h want %h", qa, 32'h4000_0000); end
`else
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL e3_nofwd_stall got %b want 1", stall); end
    checks++; if (qb !== 32'h1111_1111) begin errors++; $display("FAIL e3_nofwd_wb_qb got %h want %h", qb, 32'h1111_1111); end
    use_ft = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL e3_nofwd_unused got %b want 0", stall); end
    use_ft = 1'b1;
`endif
    // E1 and E3 both match: E1 hazard takes precedence
    e1w = 1'b1; e1n = 5'd2;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL e1_over_e3 got %b want 1", stall); end
    e1w = 1'b0; e3w = 1'b0;
    @(posedge clk); #1;
    ww = 1'b0;
    #1;
    checks++; if (qb !== 32'h1111_1111) begin errors++; $display("FAIL e3_wb_landed got %h want %h", qb, 32'h1111_1111); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    idle_inputs();
    e1w = 1'b1; e1n = 5'd9; fs = 5'd9; use_fs = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL haz_e1 got %b want 1", stall); end
    use_fs = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL haz_use0 got %b want 0", stall); end
    use_fs = 1'b1; e1w = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL haz_e1w0 got %b want 0", stall); end
    e2w = 1'b1; e2n = 5'd12; ft = 5'd12; use_ft = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL haz_e2_ft got %b want 1", stall); end
    e2n = 5'd13;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL haz_e2_miss got %b want 0", stall); end
    idle_inputs();
  endtask

  task automatic test_counter();
    @(negedge clk);
    idle_inputs();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear_idle got %0d want 0", stall_cnt); end
    @(negedge clk);
    cnt_clr = 1'b0; e1w = 1'b1; e1n = 5'd9; fs = 5'd9; use_fs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL cnt_three got %0d want 3", stall_cnt); end
    checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL cnt2_three got %0d want 3", stall_cnt2); end
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr_prio got %0d want 0", stall_cnt); end
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL cnt2_saturate got %0d want 3", stall_cnt2); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL cnt_five got %0d want 5", stall_cnt); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL cnt_hold got %0d want 5", stall_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle_inputs();
    ww = 1'b1; wn = 5'd4; wd = 32'hDEAD_BEEF;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt got %0d want 0", stall_cnt); end
    ww = 1'b0;
    #1;
    rst = 1'b0;
    fs = 5'd4; ft = 5'd5;
    #1;
    checks++; if (qa !== 32'h0) begin errors++; $display("FAIL async_reg4 got %h want %h", qa, 32'h0); end
    checks++; if (qb !== 32'h0) begin errors++; $display("FAIL async_reg5 got %h want %h", qb, 32'h0); end
    // first edge after release must accept a write
    ww = 1'b1; wn = 5'd4; wd = 32'h1234_5678;
    @(posedge clk); #1;
    ww = 1'b0; wd = 32'h0;
    #1;
    checks++; if (qa !== 32'h1234_5678) begin errors++; $display("FAIL post_rst_write got %h want %h", qa, 32'h1234_5678); end
  endtask

  initial begin
    test_reset();
    test_write_through();
    test_e3_forward();
    test_hazard();
    test_counter();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
